// File: rtl/univ_shift_reg.sv
`default_nettype none
// ============================================================================
// Module   : univ_shift_reg
// Brief    : WIDTH-bit universal register (hold/shift/rotate/load/clear) with
//            a saturating shift counter and Done flag.
// Revision : 1.0 - initial release
// ============================================================================
module univ_shift_reg #(
    parameter int WIDTH = 8,
    parameter int CNTW  = $clog2(WIDTH + 1)
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             En,
    input  logic [2:0]       Mode,
    input  logic [WIDTH-1:0] D,
    input  logic             SinMsb,
    input  logic             SinLsb,
    output logic [WIDTH-1:0] Q,
    output logic             SoutMsb,
    output logic             SoutLsb,
    output logic [CNTW-1:0]  ShiftCnt,
    output logic             Done
);

    localparam logic [2:0] c_MODE_HOLD = 3'b000;
    localparam logic [2:0] c_MODE_SHR  = 3'b001;
    localparam logic [2:0] c_MODE_SHL  = 3'b010;
    localparam logic [2:0] c_MODE_ROR  = 3'b011;
    localparam logic [2:0] c_MODE_ROL  = 3'b100;
    localparam logic [2:0] c_MODE_LOAD = 3'b101;
    localparam logic [2:0] c_MODE_CLR  = 3'b110;

    localparam logic [CNTW-1:0] c_CNT_MAX = CNTW'(WIDTH);

    logic [WIDTH-1:0] r_q;
    logic [CNTW-1:0]  r_cnt;
    logic [WIDTH-1:0] w_next_q;
    logic [CNTW-1:0]  w_next_cnt;
    logic             w_is_shift;
    logic             w_cnt_zero;

    always_comb begin
        w_next_q   = r_q;
        w_is_shift = 1'b0;
        w_cnt_zero = 1'b0;
        case (Mode)
            c_MODE_HOLD: w_next_q = r_q;
            c_MODE_SHR: begin
                w_next_q   = {SinMsb, r_q[WIDTH-1:1]};
                w_is_shift = 1'b1;
            end
            c_MODE_SHL: begin
                w_next_q   = {r_q[WIDTH-2:0], SinLsb};
                w_is_shift = 1'b1;
            end
            c_MODE_ROR: begin
                w_next_q   = {r_q[0], r_q[WIDTH-1:1]};
                w_is_shift = 1'b1;
            end
            c_MODE_ROL: begin
                w_next_q   = {r_q[WIDTH-2:0], r_q[WIDTH-1]};
                w_is_shift = 1'b1;
            end
            c_MODE_LOAD: begin
                w_next_q   = D;
                w_cnt_zero = 1'b1;
            end
            c_MODE_CLR: begin
                w_next_q   = '0;
                w_cnt_zero = 1'b1;
            end
            default: w_next_q = r_q;    // reserved encoding holds
        endcase
    end

    // Counter sticks at WIDTH so Done stays high until the next load/clear
    always_comb begin
        w_next_cnt = r_cnt;
        if (w_cnt_zero) begin
            w_next_cnt = '0;
        end else if (w_is_shift && (r_cnt != c_CNT_MAX)) begin
            w_next_cnt = r_cnt + CNTW'(1);
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_q   <= '0;
            r_cnt <= '0;
        end else if (En) begin
            r_q   <= w_next_q;
            r_cnt <= w_next_cnt;
        end
    end

    assign Q        = r_q;
    assign SoutMsb  = r_q[WIDTH-1];
    assign SoutLsb  = r_q[0];
    assign ShiftCnt = r_cnt;
    assign Done     = (r_cnt == c_CNT_MAX);

endmodule
`default_nettype wire

// File: tb/tb_univ_shift_reg.sv
`default_nettype none
// ============================================================================
// Module   : tb_univ_shift_reg
// Brief    : Directed vector table plus randomized run against a reference
//            model, exercising WIDTH=8 and WIDTH=4 instances.
// Revision : 1.0 - initial release
// ============================================================================
module tb_univ_shift_reg;

    typedef struct {
        logic       rst;
        logic       en;
        logic [2:0] mode;
        logic [7:0] d;
        logic       smsb;
        logic       slsb;
        logic [7:0] q;
        logic [3:0] cnt;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst, en, smsb, slsb;
    logic [2:0] mode;
    logic [7:0] d8;
    logic [3:0] d4;

    logic [7:0] q8;
    logic       smsb8, slsb8, done8;
    logic [3:0] cnt8;
    logic [3:0] q4;
    logic       smsb4, slsb4, done4;
    logic [2:0] cnt4;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    univ_shift_reg #(.WIDTH(8)) u_dut8 (
        .Clock(clk), .Reset(rst), .En(en), .Mode(mode), .D(d8),
        .SinMsb(smsb), .SinLsb(slsb), .Q(q8), .SoutMsb(smsb8),
        .SoutLsb(slsb8), .ShiftCnt(cnt8), .Done(done8)
    );

    univ_shift_reg #(.WIDTH(4)) u_dut4 (
        .Clock(clk), .Reset(rst), .En(en), .Mode(mode), .D(d4),
        .SinMsb(smsb), .SinLsb(slsb), .Q(q4), .SoutMsb(smsb4),
        .SoutLsb(slsb4), .ShiftCnt(cnt4), .Done(done4)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, act, exp);
        end
    endtask

    // Drive on the falling edge, sample 1 time unit after the rising edge
    task automatic step(input logic r, input logic e, input logic [2:0] m,
                        input logic [7:0] d, input logic sm, input logic sl);
        @(negedge clk);
        rst = r; en = e; mode = m; d8 = d; d4 = d[3:0]; smsb = sm; slsb = sl;
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic r, input logic e, input logic [2:0] m,
                                input logic [7:0] d, input logic sm, input logic sl,
                                input logic [7:0] q, input logic [3:0] c);
        vec_t v;
        v.rst = r; v.en = e; v.mode = m; v.d = d; v.smsb = sm; v.slsb = sl;
        v.q = q; v.cnt = c;
        return v;
    endfunction

    // Reference model: register treated as an integer of w bits
    function automatic logic [31:0] mdl_q(input int w, input logic [31:0] q,
                                          input logic r, input logic e, input logic [2:0] m,
                                          input logic [31:0] d, input logic sm, input logic sl);
        logic [31:0] mask;
        logic [31:0] msb;
        mask = 32'hFFFF_FFFF >> (32 - w);
        msb  = 32'd1 << (w - 1);
        if (r) return 32'd0;
        if (!e) return q;
        case (m)
            3'd1:    return (q >> 1) | (sm ? msb : 32'd0);
            3'd2:    return ((q << 1) | 32'(sl)) & mask;
            3'd3:    return (q >> 1) | (q[0] ? msb : 32'd0);
            3'd4:    return ((q << 1) | (q >> (w - 1))) & mask;
            3'd5:    return d & mask;
            3'd6:    return 32'd0;
            default: return q;
        endcase
    endfunction

    function automatic int mdl_cnt(input int w, input int c, input logic r,
                                   input logic e, input logic [2:0] m);
        if (r) return 0;
        if (!e) return c;
        if (m == 3'd5 || m == 3'd6) return 0;
        if (m >= 3'd1 && m <= 3'd4) return (c + 1 > w) ? w : c + 1;
        return c;
    endfunction

    initial begin
        vec_t vecs[$];
        logic [31:0] m8_q, m4_q;
        int m8_c, m4_c;

        rst = 1'b0; en = 1'b0; mode = 3'd0; d8 = 8'h00; d4 = 4'h0; smsb = 1'b0; slsb = 1'b0;

        // reset with a pending LOAD of FF
        vecs.push_back(mk(1, 1, 3'd5, 8'hFF, 0, 0, 8'h00, 4'd0));
        vecs.push_back(mk(1, 1, 3'd5, 8'hFF, 0, 0, 8'h00, 4'd0));
        // LOAD A5 then 8 x SHR
        vecs.push_back(mk(0, 1, 3'd5, 8'hA5, 0, 0, 8'hA5, 4'd0));
        vecs.push_back(mk(0, 1, 3'd1, 8'h00, 0, 0, 8'h52, 4'd1));
        vecs.push_back(mk(0, 1, 3'd1, 8'h00, 0, 0, 8'h29, 4'd2));
        vecs.push_back(mk(0, 1, 3'd1, 8'h00, 0, 0, 8'h14, 4'd3));
        vecs.push_back(mk(0, 1, 3'd1, 8'h00, 0, 0, 8'h0A, 4'd4));
        vecs.push_back(mk(0, 1, 3'd1, 8'h00, 0, 0, 8'h05, 4'd5));
        vecs.push_back(mk(0, 1, 3'd1, 8'h00, 0, 0, 8'h02, 4'd6));
        vecs.push_back(mk(0, 1, 3'd1, 8'h00, 0, 0, 8'h01, 4'd7));
        vecs.push_back(mk(0, 1, 3'd1, 8'h00, 0, 0, 8'h00, 4'd8));
        // LOAD 81, ROL x3, ROR x3
        vecs.push_back(mk(0, 1, 3'd5, 8'h81, 0, 0, 8'h81, 4'd0));
        vecs.push_back(mk(0, 1, 3'd4, 8'h00, 0, 0, 8'h03, 4'd1));
        vecs.push_back(mk(0, 1, 3'd4, 8'h00, 0, 0, 8'h06, 4'd2));
        vecs.push_back(mk(0, 1, 3'd4, 8'h00, 0, 0, 8'h0C, 4'd3));
        vecs.push_back(mk(0, 1, 3'd3, 8'h00, 0, 0, 8'h06, 4'd4));
        vecs.push_back(mk(0, 1, 3'd3, 8'h00, 0, 0, 8'h03, 4'd5));
        vecs.push_back(mk(0, 1, 3'd3, 8'h00, 0, 0, 8'h81, 4'd6));
        // LOAD 00, 10 x SHL with SinLsb=1 (saturation)
        vecs.push_back(mk(0, 1, 3'd5, 8'h00, 0, 1, 8'h00, 4'd0));
        vecs.push_back(mk(0, 1, 3'd2, 8'h00, 0, 1, 8'h01, 4'd1));
        vecs.push_back(mk(0, 1, 3'd2, 8'h00, 0, 1, 8'h03, 4'd2));
        vecs.push_back(mk(0, 1, 3'd2, 8'h00, 0, 1, 8'h07, 4'd3));
        vecs.push_back(mk(0, 1, 3'd2, 8'h00, 0, 1, 8'h0F, 4'd4));
        vecs.push_back(mk(0, 1, 3'd2, 8'h00, 0, 1, 8'h1F, 4'd5));
        vecs.push_back(mk(0, 1, 3'd2, 8'h00, 0, 1, 8'h3F, 4'd6));
        vecs.push_back(mk(0, 1, 3'd2, 8'h00, 0, 1, 8'h7F, 4'd7));
        vecs.push_back(mk(0, 1, 3'd2, 8'h00, 0, 1, 8'hFF, 4'd8));
        vecs.push_back(mk(0, 1, 3'd2, 8'h00, 0, 1, 8'hFF, 4'd8));
        vecs.push_back(mk(0, 1, 3'd2, 8'h00, 0, 1, 8'hFF, 4'd8));
        // LOAD 3C, En=0 with SHR, reserved mode holds
        vecs.push_back(mk(0, 1, 3'd5, 8'h3C, 0, 0, 8'h3C, 4'd0));
        vecs.push_back(mk(0, 0, 3'd1, 8'h00, 1, 0, 8'h3C, 4'd0));
        vecs.push_back(mk(0, 0, 3'd1, 8'h00, 1, 0, 8'h3C, 4'd0));
        vecs.push_back(mk(0, 0, 3'd1, 8'h00, 1, 0, 8'h3C, 4'd0));
        vecs.push_back(mk(0, 1, 3'd7, 8'hFF, 1, 1, 8'h3C, 4'd0));
        vecs.push_back(mk(0, 1, 3'd0, 8'hFF, 1, 1, 8'h3C, 4'd0));
        // LOAD F0, 2 x SHR, reset mid-sequence together with LOAD
        vecs.push_back(mk(0, 1, 3'd5, 8'hF0, 0, 0, 8'hF0, 4'd0));
        vecs.push_back(mk(0, 1, 3'd1, 8'h00, 0, 0, 8'h78, 4'd1));
        vecs.push_back(mk(0, 1, 3'd1, 8'h00, 0, 0, 8'h3C, 4'd2));
        vecs.push_back(mk(1, 1, 3'd5, 8'hAA, 0, 0, 8'h00, 4'd0));
        // SHR with SinMsb=1 then CLR
        vecs.push_back(mk(0, 1, 3'd5, 8'h5A, 0, 0, 8'h5A, 4'd0));
        vecs.push_back(mk(0, 1, 3'd1, 8'h00, 1, 0, 8'hAD, 4'd1));
        vecs.push_back(mk(0, 1, 3'd6, 8'hFF, 1, 1, 8'h00, 4'd0));

        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].en, vecs[i].mode, vecs[i].d, vecs[i].smsb, vecs[i].slsb);
            chk($sformatf("vec%0d_q", i), 32'(q8), 32'(vecs[i].q));
            chk($sformatf("vec%0d_cnt", i), 32'(cnt8), 32'(vecs[i].cnt));
            chk($sformatf("vec%0d_done", i), 32'(done8), 32'(vecs[i].cnt == 4'd8));
            chk($sformatf("vec%0d_slsb", i), 32'(slsb8), 32'(vecs[i].q[0]));
            chk($sformatf("vec%0d_smsb", i), 32'(smsb8), 32'(vecs[i].q[7]));
        end

        // WIDTH=4: LOAD 9, Done after exactly 4 shifts
        step(1, 0, 3'd0, 8'h00, 0, 0);
        step(0, 1, 3'd5, 8'h09, 0, 0);
        chk("w4_load_q", 32'(q4), 32'h9);
        step(0, 1, 3'd1, 8'h00, 0, 0);
        chk("w4_s1_q", 32'(q4), 32'h4);
        step(0, 1, 3'd1, 8'h00, 0, 0);
        chk("w4_s2_q", 32'(q4), 32'h2);
        step(0, 1, 3'd1, 8'h00, 0, 0);
        chk("w4_s3_q", 32'(q4), 32'h1);
        chk("w4_s3_done", 32'(done4), 32'h0);
        step(0, 1, 3'd1, 8'h00, 0, 0);
        chk("w4_s4_q", 32'(q4), 32'h0);
        chk("w4_s4_cnt", 32'(cnt4), 32'h4);
        chk("w4_s4_done", 32'(done4), 32'h1);
        step(0, 1, 3'd3, 8'h00, 0, 0);
        chk("w4_s5_cnt", 32'(cnt4), 32'h4);

        // Randomized run, both widths, against the reference model
        m8_q = 0; m4_q = 0; m8_c = 0; m4_c = 0;
        for (int n = 0; n < 400; n++) begin
            logic r, e, sm, sl;
            logic [2:0] m;
            logic [7:0] d;
            r  = (n == 0) || ($urandom_range(0, 31) == 0);
            e  = ($urandom_range(0, 3) != 0);
            m  = 3'($urandom_range(0, 7));
            // keep loads rare enough that saturation is reached
            if (m == 3'd5 || m == 3'd6) m = ($urandom_range(0, 3) == 0) ? m : 3'd1;
            d  = 8'($urandom);
            sm = 1'($urandom);
            sl = 1'($urandom);
            step(r, e, m, d, sm, sl);
            m8_c = mdl_cnt(8, m8_c, r, e, m);
            m4_c = mdl_cnt(4, m4_c, r, e, m);
            m8_q = mdl_q(8, m8_q, r, e, m, 32'(d), sm, sl);
            m4_q = mdl_q(4, m4_q, r, e, m, 32'(d), sm, sl);
            chk($sformatf("rnd%0d_q8", n), 32'(q8), m8_q);
            chk($sformatf("rnd%0d_cnt8", n), 32'(cnt8), 32'(m8_c));
            chk($sformatf("rnd%0d_done8", n), 32'(done8), 32'(m8_c == 8));
            chk($sformatf("rnd%0d_q4", n), 32'(q4), m4_q);
            chk($sformatf("rnd%0d_cnt4", n), 32'(cnt4), 32'(m4_c));
            chk($sformatf("rnd%0d_done4", n), 32'(done4), 32'(m4_c == 4));
            chk($sformatf("rnd%0d_sout4", n), 32'({smsb4, slsb4}), 32'({m4_q[3], m4_q[0]}));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
